// File: rtl/diag_func_sequencer.sv
// diag_func_sequencer: arbitrates KL10-PV EBUS diagnostic-function requests
// from NREQ requesters and runs one strobe/recovery cycle per grant toward
// the CLK module. Plain function, write (drive EBUS RH) and read (capture
// EBUS) kinds are supported.
module diag_func_sequencer #(
    parameter int         NREQ            = 2,
    parameter int         STROBE_CYCLES   = 9,
    parameter int         RECOVERY_CYCLES = 4,
    parameter logic [6:0] IDLE_DS         = 7'o000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*7-1:0]    req_func,
    input  logic [NREQ*2-1:0]    req_kind,
    input  logic [NREQ*18-1:0]   req_wdata,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [35:0]          rdata,
    output logic                 busy,
    output logic [6:0]           ds,
    output logic                 diag_strobe,
    output logic                 ebus_drive,
    output logic [17:0]          ebus_data_out,
    input  logic [35:0]          ebus_data_in
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX  = (STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES : RECOVERY_CYCLES;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        K_FUNC  = 2'd0,
        K_WRITE = 2'd1,
        K_READ  = 2'd2,
        K_RSVD  = 2'd3
    } kind_e;

    state_e             state;
    kind_e              cur_kind;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;

    logic               win_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic [6:0]         sel_func;
    logic [1:0]         sel_kind;
    logic [17:0]        sel_wdata;
    logic [NREQ-1:0]    owner_onehot;

    // Round-robin search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        logic [PTR_W:0] sum;
        win_valid = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NREQ))
                sum = sum - (PTR_W+1)'(NREQ);
            if (!win_valid && req[sum[PTR_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = sum[PTR_W-1:0];
            end
        end
    end

    // Winner field selection, grant pulse and owner decode.
    always_comb begin
        sel_func     = '0;
        sel_kind     = '0;
        sel_wdata    = '0;
        grant        = '0;
        owner_onehot = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (win_idx == PTR_W'(j)) begin
                sel_func  = req_func[7*j +: 7];
                sel_kind  = req_kind[2*j +: 2];
                sel_wdata = req_wdata[18*j +: 18];
                grant[j]  = win_valid && !rst && (state == ST_IDLE);
            end
            owner_onehot[j] = (owner == PTR_W'(j));
        end
        ptr_next = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + PTR_W'(1);
    end

    assign busy = (state != ST_IDLE);

    // Sequencer FSM: all strobe/recovery outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cur_kind      <= K_FUNC;
            owner         <= '0;
            ptr           <= '0;
            cnt           <= '0;
            ds            <= IDLE_DS;
            diag_strobe   <= 1'b0;
            ebus_drive    <= 1'b0;
            ebus_data_out <= '0;
            done          <= '0;
            rdata         <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state       <= ST_STROBE;
                        cnt         <= '0;
                        owner       <= win_idx;
                        ptr         <= ptr_next;
                        ds          <= sel_func;
                        diag_strobe <= 1'b1;
                        if (kind_e'(sel_kind) == K_WRITE) begin
                            cur_kind      <= K_WRITE;
                            ebus_drive    <= 1'b1;
                            ebus_data_out <= sel_wdata;
                        end else begin
                            // Reserved kind runs as a plain function.
                            cur_kind      <= (kind_e'(sel_kind) == K_READ) ? K_READ : K_FUNC;
                            ebus_drive    <= 1'b0;
                            ebus_data_out <= '0;
                        end
                    end
                end
                ST_STROBE: begin
                    if (cnt == CNT_W'(STROBE_CYCLES-1)) begin
                        state         <= ST_RECOVER;
                        cnt           <= '0;
                        ds            <= IDLE_DS;
                        diag_strobe   <= 1'b0;
                        ebus_drive    <= 1'b0;
                        ebus_data_out <= '0;
                        if (cur_kind == K_READ)
                            rdata <= ebus_data_in;
                        // done is raised on entry to the last recovery cycle
                        if (RECOVERY_CYCLES == 1)
                            done <= owner_onehot;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RECOVER: begin
                    if (cnt == CNT_W'(RECOVERY_CYCLES-1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(RECOVERY_CYCLES-2))
                            done <= owner_onehot;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diag_func_sequencer.sv
// tb_diag_func_sequencer: scoreboard bench for diag_func_sequencer.
module tb_diag_func_sequencer;

    localparam int         NREQ = 2;
    localparam int         S    = 9;
    localparam int         R    = 4;
    localparam logic [6:0] IDS  = 7'o000;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*7-1:0]    req_func;
    logic [NREQ*2-1:0]    req_kind;
    logic [NREQ*18-1:0]   req_wdata;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic [35:0]          rdata;
    logic                 busy;
    logic [6:0]           ds;
    logic                 diag_strobe;
    logic                 ebus_drive;
    logic [17:0]          ebus_data_out;
    logic [35:0]          ebus_data_in;

    diag_func_sequencer #(
        .NREQ(NREQ),
        .STROBE_CYCLES(S),
        .RECOVERY_CYCLES(R),
        .IDLE_DS(IDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_func(req_func),
        .req_kind(req_kind),
        .req_wdata(req_wdata),
        .grant(grant),
        .done(done),
        .rdata(rdata),
        .busy(busy),
        .ds(ds),
        .diag_strobe(diag_strobe),
        .ebus_drive(ebus_drive),
        .ebus_data_out(ebus_data_out),
        .ebus_data_in(ebus_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          owner;
        logic [6:0]  func;
        logic [1:0]  kind;
        logic [17:0] wdata;
        logic [35:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          gq_owner[$];
    int          gq_cyc[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [35:0] model_rdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int who, input logic [6:0] f, input logic [1:0] k, input logic [17:0] w);
        req[who]              = 1'b1;
        req_func[7*who +: 7]  = f;
        req_kind[2*who +: 2]  = k;
        req_wdata[18*who +: 18] = w;
    endtask

    // One complete operation from a single requester, checked cycle by cycle.
    task automatic run_op(input int who, input logic [6:0] f, input logic [1:0] k,
                          input logic [17:0] w, input logic [35:0] rd_before,
                          input logic [35:0] rd_last);
        exp_t e;
        exp_t c;
        bit   got;
        e.owner = who;
        e.func  = f;
        e.kind  = k;
        e.wdata = w;
        if (k == 2'd2)
            model_rdata = rd_last;
        e.rdata = model_rdata;
        sb.push_back(e);

        @(negedge clk);
        set_req(who, f, k, w);
        ebus_data_in = rd_before;
        #1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (grant != '0) got = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check("grant_wait", 64'(got), 64'd1);
        if (!got) begin
            void'(sb.pop_back());
            req = '0;
            return;
        end
        check("grant", 64'(grant), 64'(1 << who));
        check("busy_at_grant", 64'(busy), 64'd0);

        for (int cy = 1; cy <= S; cy++) begin
            @(negedge clk);
            if (cy == 1) begin
                // drop the request and scramble its fields after the grant
                req[who]                = 1'b0;
                req_func[7*who +: 7]    = ~f;
                req_kind[2*who +: 2]    = ~k;
                req_wdata[18*who +: 18] = ~w;
            end
            ebus_data_in = (cy == S) ? rd_last : rd_before;
            #1;
            c = sb[0];
            check("strobe_ds", 64'(ds), 64'(c.func));
            check("strobe_hi", 64'(diag_strobe), 64'd1);
            check("strobe_drive", 64'(ebus_drive), 64'(c.kind == 2'd1));
            check("strobe_data", 64'(ebus_data_out), (c.kind == 2'd1) ? 64'(c.wdata) : 64'd0);
            check("strobe_busy", 64'(busy), 64'd1);
            check("strobe_done", 64'(done), 64'd0);
        end
        for (int cy = S+1; cy <= S+R; cy++) begin
            @(negedge clk);
            #1;
            check("rec_ds", 64'(ds), 64'(IDS));
            check("rec_strobe", 64'(diag_strobe), 64'd0);
            check("rec_drive", 64'(ebus_drive), 64'd0);
            check("rec_data", 64'(ebus_data_out), 64'd0);
            check("rec_busy", 64'(busy), 64'd1);
            if (cy < S+R) begin
                check("rec_early_done", 64'(done), 64'd0);
            end else if (sb.size() == 0) begin
                check("sb_empty", 64'(done), 64'd0);
            end else begin
                c = sb.pop_front();
                check("done", 64'(done), 64'(1 << c.owner));
                check("rdata", 64'(rdata), 64'(c.rdata));
            end
        end
        @(negedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        ebus_data_in = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_next;
        int last_g;
        int ngr;
        int o;
        int gc;

        rst          = 1'b1;
        req          = '0;
        req_func     = '0;
        req_kind     = '0;
        req_wdata    = '0;
        ebus_data_in = '0;

        // reset values, including grant held off while reset is asserted
        repeat (2) @(negedge clk);
        req = 2'b01;
        #1;
        check("rst_ds", 64'(ds), 64'(IDS));
        check("rst_strobe", 64'(diag_strobe), 64'd0);
        check("rst_drive", 64'(ebus_drive), 64'd0);
        check("rst_data", 64'(ebus_data_out), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        req = '0;
        rst = 1'b0;

        run_op(0, 7'o010, 2'd0, 18'o0, 36'o0, 36'o0);
        run_op(1, 7'o044, 2'd1, 18'o000120, 36'o0, 36'o0);
        run_op(0, 7'o162, 2'd2, 18'o0, 36'o1, 36'o777);
        run_op(1, 7'o005, 2'd0, 18'o0, 36'o4, 36'o55);
        run_op(0, 7'o033, 2'd3, 18'o777777, 36'o0, 36'o123);
        run_op(1, 7'o100, 2'd2, 18'o0, 36'o5, 36'o400000000001);

        // both requesters held high from reset: grants alternate 14 apart
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        req_func = {7'o021, 7'o020};
        req_kind = '0;
        req      = 2'b11;
        rst      = 1'b0;
        exp_next = 0;
        last_g   = -1;
        ngr      = 0;
        for (int cy = 0; cy < 60; cy++) begin
            #1;
            if (grant != '0) begin
                check("rr_grant", 64'(grant), 64'(1 << exp_next));
                if (last_g >= 0)
                    check("rr_spacing", 64'(cy - last_g), 64'd14);
                gq_owner.push_back(exp_next);
                gq_cyc.push_back(cy);
                last_g   = cy;
                exp_next = exp_next ^ 1;
                ngr++;
            end
            if (done != '0) begin
                if (gq_owner.size() == 0) begin
                    check("rr_orphan_done", 64'(done), 64'd0);
                end else begin
                    o  = gq_owner.pop_front();
                    gc = gq_cyc.pop_front();
                    check("rr_done", 64'(done), 64'(1 << o));
                    check("rr_done_lat", 64'(cy - gc), 64'd13);
                end
            end
            @(negedge clk);
        end
        check("rr_count", 64'(ngr), 64'd5);
        req = '0;

        // reset in the 4th strobe cycle, pointer left at 1 beforehand
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_func[6:0] = 7'o077;
        req = 2'b01;
        #1;
        check("ab_grant", 64'(grant), 64'd1);
        for (int cy = 1; cy <= 4; cy++) begin
            @(negedge clk);
            req = '0;
        end
        #1;
        check("ab_in_strobe", 64'(diag_strobe), 64'd1);
        rst = 1'b1;
        #1;
        check("ab_ds", 64'(ds), 64'(IDS));
        check("ab_strobe", 64'(diag_strobe), 64'd0);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_done", 64'(done), 64'd0);
        check("ab_drive", 64'(ebus_drive), 64'd0);
        req = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ab_first_grant", 64'(grant), 64'd1);
        for (int cy = 1; cy <= 13; cy++) begin
            @(negedge clk);
            req = '0;
            #1;
            if (cy < 13)
                check("ab_no_done", 64'(done), 64'd0);
            else
                check("ab_done_after", 64'(done), 64'd1);
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/diag_func_sequencer.md
Name: diag_func_sequencer

Overview:
Synthesizable owner of the KL10-PV EBUS diagnostic-function interface toward the CLK module. It shares that interface among NREQ requesters, such as the DTE and the boot/master-reset sequencer. Each accepted request becomes one diagnostic cycle: assert `ds` and `diag_strobe`, hold them, deassert, then observe a recovery gap. Three request kinds exist: plain function, write (drive EBUS data RH) and read (capture EBUS data).

Parameters:
NREQ, 2, number of requesters (1..8)
STROBE_CYCLES, 9, cycles `ds`/`diag_strobe` held asserted (>=1)
RECOVERY_CYCLES, 4, idle cycles after strobe deassert before done (>=1)
IDLE_DS, 7'o000, `ds` value driven when no function is active

Ports:
clk  in  1  CLK 10/11 clock; all logic on posedge
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester request level
req_func  in  NREQ*7  diag function code, requester i at [7i+6:7i]
req_kind  in  NREQ*2  per requester: 0=FUNC, 1=WRITE, 2=READ, 3=reserved (treated as FUNC)
req_wdata  in  NREQ*18  EBUS RH write data, requester i at [18i+17:18i]
grant  out  NREQ  one-cycle pulse: request accepted, fields sampled
done  out  NREQ  one-cycle pulse: operation complete
rdata  out  36  last READ capture, EBUS bits 0..35 MSB-first
busy  out  1  high whenever state != IDLE
ds  out  7  diag select to CLK
diag_strobe  out  1  diag strobe
ebus_drive  out  1  high while driving EBUS data
ebus_data_out  out  18  EBUS data RH (bits 18..35); zero when not driving
ebus_data_in  in  36  EBUS data bus

Behaviour:
- Reset values (immediate, asynchronous): state=IDLE, ds=IDLE_DS, diag_strobe=0, ebus_drive=0, ebus_data_out=0, grant=0, done=0, rdata=0, busy=0, rr pointer=0, counter=0.
- States: IDLE -> STROBE -> RECOVER -> IDLE.
- IDLE with any req bit high:
  - Pick the winner round-robin, starting at pointer p and searching p, p+1, ... mod NREQ.
  - Pulse grant[winner] this cycle.
  - Latch func, kind, wdata and owner.
  - Set p=winner+1 mod NREQ.
  - Next state: STROBE.
- IDLE with no req: outputs stay at their idle values.
- STROBE lasts exactly STROBE_CYCLES cycles:
  - ds=latched func, diag_strobe=1.
  - If kind=WRITE: ebus_drive=1 and ebus_data_out=latched wdata. Otherwise ebus_drive=0 and ebus_data_out=0.
  - For READ, on the final STROBE cycle's clock edge, rdata <= ebus_data_in.
- RECOVER lasts exactly RECOVERY_CYCLES cycles:
  - ds=IDLE_DS, diag_strobe=0, ebus_drive=0, ebus_data_out=0.
  - done[owner] pulses in the last RECOVER cycle.
  - Next state: IDLE.
- Timing:
  - grant at cycle T.
  - Strobe high over T+1..T+STROBE_CYCLES.
  - done at T+STROBE_CYCLES+RECOVERY_CYCLES.
  - Next grant no earlier than the following cycle, so back-to-back period = 1+S+R = 14 cycles at defaults.
- All STROBE/RECOVER outputs are registered: glitch-free, no combinational path from req to ds/strobe.
- Request fields are sampled only in the grant cycle. Changes or deassertion of req after grant do not affect the operation in progress.
- A req still high in the IDLE cycle after done is a new request.
- rdata holds its value until the next READ capture; FUNC and WRITE leave it unchanged.
- Reserved kind=3 is executed as FUNC (no drive, no capture).
- Reset mid-operation: outputs go to idle values asynchronously; the aborted owner gets no done; the pointer returns to 0.
- NREQ=1: arbitration degenerates to fixed grant; same timing.

Test Plan:
1. req[0]=1, FUNC, func=7'o010 at grant cycle T -> ds=7'o010 and diag_strobe=1 for cycles T+1..T+9, ebus_drive=0 throughout, done[0] at T+13, busy high T+1..T+13.
2. req[1], WRITE, func=7'o044, wdata=18'o000120 -> ebus_drive=1 and ebus_data_out=18'o000120 only during the 9 strobe cycles; 0 before and after; grant[1] and done[1] only.
3. READ, func=7'o162; ebus_data_in=36'o1 until the last strobe cycle, then 36'o777 during it -> rdata=36'o777 captured on that cycle's edge and visible at done. A following FUNC leaves rdata=36'o777.
4. req=2'b11 held continuously from reset -> grants alternate 0,1,0,1 at 14-cycle spacing; no done without a matching prior grant.
5. rst asserted in the 4th STROBE cycle -> same-cycle ds=IDLE_DS, diag_strobe=0, busy=0, no done. After release with req=2'b11, requester 0 wins first.
6. req[0] dropped and req_func changed one cycle after grant -> operation completes with the originally sampled func, and done[0] arrives on schedule.
